// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with configurable width/depth, standard or first-word-fall-through read,
// almost-full/almost-empty thresholds, occupancy count and sticky overflow/underflow flags.
module sync_fifo_flex #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter bit          FWFT       = 1'b0,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       r_en,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, udf_q;
   logic                  wr_acc, rd_acc;

   // Flags come from the registered count, so a same-cycle pop never frees a slot for a push.
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   assign wr_acc = w_en && !full;
   assign rd_acc = r_en && !empty;

   always_comb begin
      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         // Setting takes priority over a simultaneous clear.
         if (w_en && full) begin
            ovf_q <= 1'b1;
         end else if (err_clr) begin
            ovf_q <= 1'b0;
         end
         if (r_en && empty) begin
            udf_q <= 1'b1;
         end else if (err_clr) begin
            udf_q <= 1'b0;
         end
      end
   end

   // Storage is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   generate
      if (FWFT) begin : gen_fwft
         assign data_out = empty ? '0 : mem[rd_ptr_q];
      end else begin : gen_std
         logic [DATA_WIDTH-1:0] dout_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dout_q <= '0;
            end else if (rd_acc) begin
               dout_q <= mem[rd_ptr_q];
            end
         end

         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: drives a standard and an FWFT instance in lockstep and checks both
// against a queue-based model every cycle, plus hand-computed expectations for key scenarios.
module tb_sync_fifo_flex;

   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int AF = DEPTH - 2;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [4:0]    s_count, f_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // Reference model state.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout0 = '0;
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   bit            m_full, m_empty;

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf),
      .err_clr(err_clr)
   );

   sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf),
      .err_clr(err_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_dout0 = '0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_full = (q.size() == DEPTH);
         m_empty = (q.size() == 0);
         m_ovf = (w_en && m_full) ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
         m_udf = (r_en && m_empty) ? 1'b1 : (err_clr ? 1'b0 : m_udf);
         if (r_en && !m_empty) m_dout0 = q.pop_front();
         if (w_en && !m_full) q.push_back(data_in);
      end
   end

   function automatic logic [DW-1:0] m_fwft();
      return (q.size() != 0) ? q[0] : '0;
   endfunction

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("std_count", s_count, q.size());
         check("std_full", s_full, q.size() == DEPTH);
         check("std_empty", s_empty, q.size() == 0);
         check("std_af", s_af, q.size() >= AF);
         check("std_ae", s_ae, q.size() <= AE);
         check("std_ovf", s_ovf, m_ovf);
         check("std_udf", s_udf, m_udf);
         check("std_dout", s_dout, m_dout0);
         check("fwft_count", f_count, q.size());
         check("fwft_full", f_full, q.size() == DEPTH);
         check("fwft_empty", f_empty, q.size() == 0);
         check("fwft_ovf", f_ovf, m_ovf);
         check("fwft_udf", f_udf, m_udf);
         check("fwft_dout", f_dout, m_fwft());
      end
   end

   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      @(negedge clk);
      #1;
      w_en = w;
      data_in = d;
      r_en = r;
      err_clr = c;
      @(posedge clk);
      #1;
      w_en = 1'b0;
      r_en = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_count"}, s_count, 0);
      check({tag, "_empty"}, s_empty, 1);
      check({tag, "_full"}, s_full, 0);
      check({tag, "_ae"}, s_ae, 1);
      check({tag, "_af"}, s_af, 0);
      check({tag, "_sdout"}, s_dout, 0);
      check({tag, "_fdout"}, f_dout, 0);
      check({tag, "_ovf"}, s_ovf, 0);
      check({tag, "_udf"}, s_udf, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      check_reset_vals("rst");
      chk_en = 1'b1;

      // Basic write/read ordering.
      step(1, 8'h11, 0, 0);
      check("w1_count", s_count, 1);
      check("w1_empty", s_empty, 0);
      check("w1_fwft", f_dout, 8'h11);
      step(1, 8'h22, 0, 0);
      check("w2_count", s_count, 2);
      step(1, 8'h33, 0, 0);
      check("w3_count", s_count, 3);
      step(0, 0, 1, 0);
      check("r1_dout", s_dout, 8'h11);
      step(0, 0, 1, 0);
      check("r2_dout", s_dout, 8'h22);
      step(0, 0, 1, 0);
      check("r3_dout", s_dout, 8'h33);
      check("r3_empty", s_empty, 1);

      // Fill to capacity, then overflow.
      for (int i = 1; i <= DEPTH; i++) begin
         step(1, 8'h40 + 8'(i - 1), 0, 0);
         if (i == 13) check("fill13_af", s_af, 0);
         if (i == 14) check("fill14_af", s_af, 1);
         if (i == 15) check("fill15_full", s_full, 0);
      end
      check("fill_full", s_full, 1);
      step(1, 8'hEE, 0, 0);
      check("ovf_set", s_ovf, 1);
      check("ovf_count", s_count, 16);
      check("ovf_head", f_dout, 8'h40);
      step(0, 0, 0, 1);
      check("ovf_clr", s_ovf, 0);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 1, 0);
         if (i == 0) check("drain_first", s_dout, 8'h40);
      end
      check("drain_last", s_dout, 8'h4F);

      // Underflow and set-beats-clear.
      step(0, 0, 1, 0);
      check("udf_set", s_udf, 1);
      check("udf_count", s_count, 0);
      check("udf_hold", s_dout, 8'h4F);
      step(0, 0, 0, 1);
      check("udf_clr", s_udf, 0);
      step(0, 0, 1, 1);
      check("udf_set_wins", s_udf, 1);
      step(0, 0, 0, 1);

      // Simultaneous push/pop at count 5 across pointer wrap.
      for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, 8'h80 + 8'(i), 1, 0);
         if (i == 0) check("sim_first", s_dout, 8'h60);
      end
      check("sim_count", s_count, 5);
      check("sim_last", s_dout, 8'h8E);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
      check("sim_drain", s_dout, 8'h93);

      // FWFT visibility.
      step(1, 8'hA5, 0, 0);
      check("fwft_a5", f_dout, 8'hA5);
      step(1, 8'h5A, 0, 0);
      check("fwft_hold", f_dout, 8'hA5);
      step(0, 0, 1, 0);
      check("fwft_5a", f_dout, 8'h5A);

      // Asynchronous reset mid-operation at count 9.
      for (int i = 0; i < 8; i++) step(1, 8'hC0 + 8'(i), 0, 0);
      check("pre_rst_count", s_count, 9);
      #1 rst = 1'b1;
      #1 check_reset_vals("midrst");
      #1 rst = 1'b0;
      step(1, 8'h77, 0, 0);
      check("postrst_fwft", f_dout, 8'h77);
      check("postrst_count", s_count, 1);
      step(0, 0, 1, 0);
      check("postrst_std", s_dout, 8'h77);
      check("postrst_empty", s_empty, 1);

      // Randomized traffic with varying fill bias.
      for (int seg = 0; seg < 4; seg++) begin
         int wp;
         int rp;
         wp = (seg == 0) ? 80 : (seg == 1) ? 20 : 55;
         rp = (seg == 0) ? 20 : (seg == 1) ? 80 : 50;
         for (int i = 0; i < 200; i++) begin
            step(($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < rp),
                 ($urandom_range(99) < 5));
         end
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised successor to the team's asynchronous FIFO.
- Intended for same-domain buffering where CDC is not needed.
- Adds configurable width and depth, selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Sits between a producer and consumer in one clock domain, using the same data_in/data_out/w_en/r_en/full/empty handshake as the existing FIFO.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- DEPTH, 16, number of entries; power of two, minimum 4.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- w_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- r_en  input  1  read request.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- err_clr  input  1  clears overflow and underflow.

Behaviour:
- Reset (rst high, asynchronous):
  - write pointer, read pointer and count go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (AF_THRESH is at least 1).
  - data_out=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data. The first write after release lands at address 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accept rules:
  - Write accepted iff w_en && !full, sampled at the edge.
  - Read accepted iff r_en && !empty.
  - full and empty are the registered-state values before the edge. A same-cycle read never makes room for a write when full, and a same-cycle write never satisfies a read when empty.
- Count:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted; both pointers advance.
- Flags are decoded from the count register, so they change in the cycle after the accepting edge.
- FWFT=0:
  - data_out is a register loaded with mem[rd_ptr] on the edge of an accepted read. Data is valid from the cycle after r_en.
  - data_out holds its value otherwise, including when the FIFO goes empty.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally whenever !empty. It is 0 when empty.
  - An accepted read pops the current word, and the next word appears after the edge.
  - The first written word becomes visible the cycle after its write, when empty deasserts.
- Errors:
  - overflow is set on an edge with w_en && full.
  - underflow is set on an edge with r_en && empty.
  - err_clr clears both. If set and clear occur on the same edge, set wins.
  - Rejected requests do not change the pointers, count or memory.
- Thresholds are compared as unsigned values against count.

Test Plan:
- Defaults, FWFT=0: reset, then write 0x11, 0x22, 0x33 on consecutive edges. count steps 1,2,3 and empty drops after the first edge. Three reads then return 0x11, 0x22, 0x33, each one cycle after its r_en, and empty=1 after the third read.
- Fill to capacity: write 16 words. almost_full rises when count=14 and full rises at 16. A 17th write sets overflow=1 with count still 16 and no data corrupted. err_clr pulses overflow back to 0.
- Empty read: r_en on an empty FIFO sets underflow=1, count stays 0 and data_out is unchanged. Simultaneous err_clr and r_en on an empty FIFO leaves underflow=1.
- Simultaneous: at count=5, w_en and r_en together for 20 cycles. count stays 5, the pointers wrap past 15 and data order is preserved (scoreboard queue compare, as in the existing FIFO bench).
- FWFT=1: write 0xA5. data_out=0xA5 the cycle empty deasserts, with no r_en needed. Write 0x5A and read once, then data_out=0x5A.
- Mid-operation reset: at count=9, pulse rst asynchronously between edges. Outputs immediately go to their reset values, and the next write/read pair returns the newly written data.
